// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths, capture state encoding and offset-binary conversion
package adc_pkg;
    localparam int ADC_W_DEF        = 12;
    localparam int CNT_W_DEF        = 16;
    localparam int MAX_AVG_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_e;

    // Flipping the MSB of an offset-binary code yields its two's complement value.
    function automatic logic [31:0] offset_to_twos(input logic [31:0] raw, input int width);
        return raw ^ (32'd1 << (width - 1));
    endfunction
endpackage

// File: rtl/adc_capture_ctrl_if.sv
// rtl/adc_capture_ctrl_if.sv - trigger, config, ADC bus and sample output bundle
interface adc_capture_ctrl_if import adc_pkg::*; #(
    parameter int ADC_W = ADC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_delay;
    logic [2:0]       cfg_avg_log2;
    logic             cfg_signed;
    logic [ADC_W-1:0] ADC_D;
    logic [ADC_W-1:0] DOUT;
    logic             DOUT_vld;
    logic [CNT_W-1:0] sample_num;
    logic             busy;
    logic             finish;
    logic             aborted;

    modport master (
        output start, abort, cfg_len, cfg_delay, cfg_avg_log2, cfg_signed, ADC_D,
        input  DOUT, DOUT_vld, sample_num, busy, finish, aborted
    );

    modport slave (
        input  start, abort, cfg_len, cfg_delay, cfg_avg_log2, cfg_signed, ADC_D,
        output DOUT, DOUT_vld, sample_num, busy, finish, aborted
    );
endinterface

// File: rtl/adc_sample_conv.sv
// rtl/adc_sample_conv.sv - ADC input register with optional offset-binary to two's complement
module adc_sample_conv import adc_pkg::*; #(
    parameter int ADC_W = ADC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_d,
    input  logic             conv_signed,
    output logic [ADC_W-1:0] conv
);
    logic [ADC_W-1:0] adc_z;

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_z <= '0;
        end else begin
            adc_z <= adc_d;
        end
    end

    assign conv = conv_signed ? ADC_W'(offset_to_twos(32'(adc_z), ADC_W)) : adc_z;
endmodule

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - triggered, delayed, block-averaging ADC capture controller
module adc_capture_ctrl import adc_pkg::*; #(
    parameter int ADC_W        = ADC_W_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int MAX_AVG_LOG2 = MAX_AVG_LOG2_DEF
) (
    input logic               clk,
    input logic               reset,
    adc_capture_ctrl_if.slave bus
);
    localparam int         ACC_W = ADC_W + MAX_AVG_LOG2 + 1;
    localparam int         SUB_W = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
    localparam logic [2:0] K_MAX = 3'(MAX_AVG_LOG2);

    cap_state_e              state;
    logic                    start_z;
    logic                    start_zz;
    logic [CNT_W-1:0]        len_lat;
    logic [CNT_W-1:0]        dly_cnt;
    logic [CNT_W-1:0]        out_cnt;
    logic [2:0]              k_lat;
    logic                    signed_lat;
    logic signed [ACC_W-1:0] acc;
    logic [SUB_W-1:0]        sub_cnt;

    logic [ADC_W-1:0]        conv;
    logic signed [ACC_W-1:0] conv_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic [ADC_W-1:0]        dout_next;
    logic [SUB_W-1:0]        sub_last;
    logic                    sub_done;
    logic                    last_out;
    logic                    trig;
    logic [2:0]              k_cfg;

    adc_sample_conv #(.ADC_W(ADC_W)) u_conv (
        .clk         (clk),
        .reset       (reset),
        .adc_d       (bus.ADC_D),
        .conv_signed (signed_lat),
        .conv        (conv)
    );

    always_comb begin
        if (signed_lat) begin
            conv_ext  = {{(ACC_W-ADC_W){conv[ADC_W-1]}}, conv};
        end else begin
            conv_ext  = {{(ACC_W-ADC_W){1'b0}}, conv};
        end
        acc_sum = acc + conv_ext;
        // Signed blocks floor-divide; unsigned blocks never see a set MSB, so a logical shift suffices.
        if (signed_lat) begin
            dout_next = ADC_W'(acc_sum >>> k_lat);
        end else begin
            dout_next = ADC_W'($unsigned(acc_sum) >> k_lat);
        end
        sub_last = SUB_W'((32'd1 << k_lat) - 32'd1);
        sub_done = (sub_cnt == sub_last);
        last_out = sub_done && (out_cnt == len_lat - CNT_W'(1));
        trig     = start_z && !start_zz;
        k_cfg    = (bus.cfg_avg_log2 > K_MAX) ? K_MAX : bus.cfg_avg_log2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            start_z        <= 1'b0;
            start_zz       <= 1'b0;
            len_lat        <= '0;
            dly_cnt        <= '0;
            out_cnt        <= '0;
            k_lat          <= '0;
            signed_lat     <= 1'b0;
            acc            <= '0;
            sub_cnt        <= '0;
            bus.DOUT       <= '0;
            bus.DOUT_vld   <= 1'b0;
            bus.sample_num <= '0;
            bus.busy       <= 1'b0;
            bus.finish     <= 1'b0;
            bus.aborted    <= 1'b0;
        end else begin
            start_z      <= bus.start;
            start_zz     <= start_z;
            bus.DOUT_vld <= 1'b0;
            bus.finish   <= 1'b0;
            bus.aborted  <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        len_lat    <= bus.cfg_len;
                        dly_cnt    <= bus.cfg_delay;
                        k_lat      <= k_cfg;
                        signed_lat <= bus.cfg_signed;
                        acc        <= '0;
                        sub_cnt    <= '0;
                        out_cnt    <= '0;
                        if (bus.cfg_len == '0) begin
                            bus.finish <= 1'b1;
                        end else begin
                            state    <= (bus.cfg_delay == '0) ? CAPTURE : DELAY;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (bus.abort) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.aborted <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt - CNT_W'(1);
                        if (dly_cnt == CNT_W'(1)) begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    // A final output coinciding with abort still completes normally.
                    if (bus.abort && !last_out) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.aborted <= 1'b1;
                    end else if (sub_done) begin
                        bus.DOUT       <= dout_next;
                        bus.DOUT_vld   <= 1'b1;
                        bus.sample_num <= out_cnt;
                        out_cnt        <= out_cnt + CNT_W'(1);
                        acc            <= '0;
                        sub_cnt        <= '0;
                        if (last_out) begin
                            state      <= IDLE;
                            bus.busy   <= 1'b0;
                            bus.finish <= 1'b1;
                        end
                    end else begin
                        acc     <= acc_sum;
                        sub_cnt <= sub_cnt + SUB_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - randomized capture runs checked against an edge-indexed reference model
module tb_adc_capture_ctrl;
    localparam int ADC_W = 12;
    localparam int CNT_W = 16;
    localparam int MAXK  = 4;
    localparam int NMAX  = 32768;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    adc_capture_ctrl_if #(.ADC_W(ADC_W), .CNT_W(CNT_W)) bus ();

    adc_capture_ctrl #(.ADC_W(ADC_W), .CNT_W(CNT_W), .MAX_AVG_LOG2(MAXK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int adc_arr  [NMAX];
    bit exp_vld  [NMAX];
    bit exp_fin  [NMAX];
    bit exp_ab   [NMAX];
    bit exp_busy [NMAX];
    bit exp_rst  [NMAX];
    int exp_dout [NMAX];
    int exp_snum [NMAX];
    int held_dout = 0;
    int held_snum = 0;

    task automatic check(input string tag, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s edge %0d: got 0x%0h expected 0x%0h", tag, cyc, got, want);
        end
    endtask

    // Outputs after edge n are compared against what the model says edge n produces.
    task automatic monitor();
        int n = cyc;
        if (exp_rst[n]) begin
            held_dout = 0;
            held_snum = 0;
        end
        if (exp_vld[n]) begin
            held_dout = exp_dout[n];
            held_snum = exp_snum[n];
        end
        check("DOUT_vld",   bus.DOUT_vld,   exp_vld[n]);
        check("DOUT",       bus.DOUT,       held_dout);
        check("sample_num", bus.sample_num, held_snum);
        check("busy",       bus.busy,       exp_busy[n]);
        check("finish",     bus.finish,     exp_fin[n]);
        check("aborted",    bus.aborted,    exp_ab[n]);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        bus.ADC_D = 12'(adc_arr[cyc+1]);
        @(negedge clk);
        monitor();
    endtask

    task automatic plan(input int e0, input int len, input int d, input int kraw,
                        input bit sgn, input int kill, input bit kill_rst);
        int k, n, fin_edge, end_edge, oe, s, v;
        bit cut;
        k = (kraw > MAXK) ? MAXK : kraw;
        n = 1 << k;
        fin_edge = e0 + d + len * n;
        if (len == 0) begin
            exp_fin[e0] = 1'b1;
            return;
        end
        cut = (kill > e0) && (kill_rst ? (kill <= fin_edge) : (kill < fin_edge));
        end_edge = cut ? kill : fin_edge;
        for (int e = e0; e < end_edge; e++) exp_busy[e] = 1'b1;
        for (int j = 0; j < len; j++) begin
            oe = e0 + d + (j + 1) * n;
            if (!cut || oe < end_edge) begin
                s = 0;
                for (int i = 0; i < n; i++) begin
                    v = adc_arr[e0 + d + j * n + i];
                    s += sgn ? v - 2048 : v;
                end
                s = s >>> k;
                exp_vld[oe]  = 1'b1;
                exp_dout[oe] = s & 'hFFF;
                exp_snum[oe] = j;
            end
        end
        if (!cut) exp_fin[fin_edge] = 1'b1;
        else if (!kill_rst) exp_ab[kill] = 1'b1;
    endtask

    task automatic run(input int len, input int d, input int kraw, input bit sgn,
                       input int kill_off, input bit kill_rst, input bit retrig);
        int e0, k, fin_edge, kill, stop;
        e0 = cyc + 2;
        k = (kraw > MAXK) ? MAXK : kraw;
        fin_edge = e0 + d + len * (1 << k);
        kill = (kill_off > 0) ? e0 + kill_off : 0;
        bus.cfg_len      = CNT_W'(len);
        bus.cfg_delay    = CNT_W'(d);
        bus.cfg_avg_log2 = 3'(kraw);
        bus.cfg_signed   = sgn;
        bus.start        = 1'b1;
        plan(e0, len, d, kraw, sgn, kill, kill_rst);
        if (kill_rst && kill > 0) exp_rst[kill] = 1'b1;
        tick();
        tick();
        bus.start        = 1'b0;
        bus.cfg_len      = CNT_W'($urandom_range(0, 20));
        bus.cfg_delay    = CNT_W'($urandom_range(0, 20));
        bus.cfg_avg_log2 = 3'($urandom_range(0, 7));
        bus.cfg_signed   = 1'($urandom_range(0, 1));
        if (retrig && len > 0 && fin_edge >= e0 + 3) begin
            tick();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        if (kill > 0) begin
            while (cyc < kill - 1) tick();
            if (kill_rst) reset = 1'b1;
            else bus.abort = 1'b1;
            tick();
            reset     = 1'b0;
            bus.abort = 1'b0;
        end
        stop = ((kill > fin_edge) ? kill : fin_edge) + 3;
        while (cyc < stop) tick();
    endtask

    int conv_in  [3] = '{'h000, 'h800, 'hFFF};
    int conv_out [3] = '{'h800, 'h000, 'h7FF};

    initial begin
        int len, d, kraw, span, kill_off, sel;
        bit sgn, krst, rtg;
        for (int i = 0; i < NMAX; i++) adc_arr[i] = $urandom_range(0, 4095);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_len = '0;
        bus.cfg_delay = '0;
        bus.cfg_avg_log2 = '0;
        bus.cfg_signed = 1'b0;
        bus.ADC_D = 12'(adc_arr[1]);
        for (int i = 1; i <= 3; i++) exp_rst[i] = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();

        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i < 20; i++) adc_arr[cyc + i] = conv_in[r];
            run(3, 0, 0, 1'b1, 0, 1'b0, 1'b0);
            check("conv_dout", bus.DOUT, conv_out[r]);
        end

        for (int i = 0; i < 20; i++) adc_arr[cyc + 2 + i] = i;
        run(8, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        check("ramp_last_dout", bus.DOUT, 7);
        check("ramp_last_snum", bus.sample_num, 7);

        for (int i = 0; i < 40; i++) adc_arr[cyc + 1 + i] = (i % 2) ? 104 : 100;
        run(4, 5, 2, 1'b0, 0, 1'b0, 1'b0);
        check("avg_dout", bus.DOUT, 102);

        run(6, 2, 1, 1'b0, 7, 1'b0, 1'b0);
        check("abort_snum", bus.sample_num, 1);
        run(5, 3, 1, 1'b1, 0, 1'b0, 1'b1);
        run(0, 4, 2, 1'b0, 0, 1'b0, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
        run(4, 20, 0, 1'b0, 5, 1'b1, 1'b0);
        run(10, 1, 1, 1'b1, 8, 1'b1, 1'b0);
        check("rst_dout", bus.DOUT, 0);
        run(3, 2, 1, 1'b0, 0, 1'b0, 1'b0);
        run(2, 0, 7, 1'b1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            len  = $urandom_range(0, 10);
            d    = $urandom_range(0, 8);
            kraw = $urandom_range(0, 7);
            sgn  = 1'($urandom_range(0, 1));
            span = d + len * (1 << ((kraw > MAXK) ? MAXK : kraw));
            sel  = $urandom_range(0, 9);
            kill_off = 0;
            krst = 1'b0;
            rtg  = 1'b0;
            if (sel < 2) kill_off = $urandom_range(1, span + 2);
            else if (sel == 2) begin
                kill_off = $urandom_range(1, span + 2);
                krst = 1'b1;
            end else if (sel < 5) rtg = 1'b1;
            run(len, d, kraw, sgn, kill_off, krst, rtg);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Parametrised successor of the single-shot ADC capture block.
- Synchronises a start trigger, waits a programmable pre-capture delay, then captures a programmable number of samples.
- Optionally converts offset-binary to two's complement and block-averages 2^k raw samples per output.
- Sits between the ADC pins and the sample RAM/FIFO writer; supports abort.

Parameters:
ADC_W, 12, ADC sample width in bits
CNT_W, 16, width of length/delay/sample counters
MAX_AVG_LOG2, 4, largest averaging exponent supported

Ports:
clk  in  1  system clock; ADC_D is synchronous to it
reset  in  1  synchronous, active-high reset
start  in  1  trigger, async level; capture arms on its synchronised rising edge
abort  in  1  stops a capture in progress
cfg_len  in  CNT_W  number of output samples per capture
cfg_delay  in  CNT_W  cycles between trigger edge and capture start
cfg_avg_log2  in  3  averaging exponent k; values above MAX_AVG_LOG2 clamp to MAX_AVG_LOG2
cfg_signed  in  1  1: offset-binary to two's complement; 0: raw unsigned
ADC_D  in  ADC_W  ADC data bus
DOUT  out  ADC_W  averaged/converted sample
DOUT_vld  out  1  one-cycle strobe per DOUT
sample_num  out  CNT_W  index of current DOUT, starting at 0
busy  out  1  high in DELAY and CAPTURE
finish  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort

Behaviour:
- Reset is synchronous and active-high. While reset is high at an edge:
  - state goes to IDLE;
  - DOUT, DOUT_vld, sample_num, busy, finish, aborted, accumulators, counters and sync flops are all cleared to 0.
- Reset mid-capture discards the capture, with no finish and no aborted pulse.
- Start edge detection:
  - start passes through two flops, start_z then start_zz.
  - The trigger edge E0 is a clock edge at which start_z=1 and start_zz=0 (pre-edge values) and state=IDLE.
  - Edges occurring in any other state are ignored, not queued.
- Config latch: cfg_len, cfg_delay, clamped cfg_avg_log2 and cfg_signed are latched at E0. Changes after E0 have no effect until the next capture.
- Input path: ADC_D is registered into adc_z every cycle.
  - cfg_signed=1: conv = {~adc_z[MSB], adc_z[MSB-1:0]}, i.e. adc_z − 2^(ADC_W−1), as two's complement.
  - cfg_signed=0: conv = adc_z, unsigned.
- States:
  - IDLE:
    - At E0 with len=0: stay IDLE and pulse finish at E0; no DOUT_vld.
    - At E0 with D=0: go to CAPTURE.
    - At E0 otherwise: go to DELAY with dly_cnt=D.
  - DELAY: dly_cnt decrements each edge. At the edge where dly_cnt==1, go to CAPTURE. The CAPTURE state is therefore entered at edge E0+D.
  - CAPTURE: each edge adds conv to acc (width ADC_W+MAX_AVG_LOG2+1) and increments sub_cnt. At the edge where sub_cnt==2^k−1:
    - DOUT <= (acc+conv) >> k, arithmetic if signed, logical if unsigned, truncated to ADC_W;
    - DOUT_vld <= 1;
    - sample_num <= out_cnt;
    - out_cnt++;
    - acc and sub_cnt are cleared.
  - Completion: when out_cnt==len−1 at an output edge, go to IDLE and finish <= 1 on the same edge as the last DOUT_vld.
- Timing:
  - First DOUT_vld edge is E0+D+2^k, then one every 2^k edges.
  - finish edge is E0+D+len·2^k.
  - If start is first sampled high at edge S0, then E0 = S0+1.
- Abort: abort=1 at an edge in DELAY or CAPTURE sends the state to IDLE and pulses aborted.
  - If abort coincides with the final output edge, the output and finish are still produced and aborted is not pulsed (completion wins).
  - abort in IDLE is ignored.
- busy=1 exactly while state is DELAY or CAPTURE.
- Counter bounds: len up to 2^CNT_W−1. Counters never wrap within a capture.

Decomposition:
- Shared package adc_pkg holds:
  - ADC_W and CNT_W defaults and MAX_AVG_LOG2;
  - the state enum (IDLE, DELAY, CAPTURE);
  - the offset-conversion function.
- One sub-module, adc_sample_conv: input register plus offset-binary conversion. Everything else stays in adc_capture_ctrl.

Test Plan:
- Conversion check (cfg_signed=1, k=0, len=3, D=0), ADC_D held at 0x000, 0x800, 0xFFF in successive runs -> DOUT = 0x800 (−2048), 0x000, 0x7FF.
- Timing check (len=8, D=0, k=0, ADC_D ramp 0..), start rises before S0 -> DOUT_vld on edges S0+2..S0+9, sample_num 0..7, finish on S0+9 only.
- Averaging check (D=5, k=2, len=4, cfg_signed=0, ADC_D alternating 100/104) -> four DOUT=102, spaced 4 cycles apart, first at E0+9, finish at E0+21.
- Abort and retrigger: abort during CAPTURE after 2 outputs -> aborted pulse, busy=0 next cycle, no finish, no further DOUT_vld; a start pulse during busy produces no extra capture.
- Zero length (len=0) -> finish pulse at E0, no DOUT_vld, busy stays 0.
- Reset mid-capture: reset asserted mid-DELAY and mid-CAPTURE -> all outputs 0 on the following cycle, no finish or aborted; a new start then captures normally.
